// File: rtl/uart_tx.sv
// uart_tx: 8-bit even-parity UART transmitter (1 or 2 stop bits) with a one-byte holding register.
// Latency: accept at edge k drives start bit at edge k+1 when idle; o_ready low while a byte is held.
`timescale 1ns/1ps
module uart_tx #(
    parameter int p_clk_freq  = 50000000,
    parameter int p_baud_freq = 115200,
    parameter int p_stop_bits = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);
    localparam int                  lp_div      = p_clk_freq / p_baud_freq;
    localparam int                  lp_cnt_w    = (lp_div > 2) ? $clog2(lp_div) : 1;
    localparam logic [lp_cnt_w-1:0] lp_cnt_max  = lp_cnt_w'(lp_div - 1);
    localparam logic [lp_cnt_w-1:0] lp_cnt_one  = lp_cnt_w'(1);
    localparam logic                lp_two_stop = (p_stop_bits == 2);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]          r_state;
    logic [lp_cnt_w-1:0] r_cnt;
    logic [2:0]          r_idx;
    logic [7:0]          r_shift;
    logic                r_parity;
    logic                r_stop_idx;
    logic                r_hold_valid;
    logic [7:0]          r_hold_data;
    logic                r_tx;
    logic                r_done;

    logic w_accept;
    logic w_bit_end;
    logic w_stop_end;
    logic w_load;

    assign w_accept   = i_valid & ~r_hold_valid;
    assign w_bit_end  = (r_cnt == lp_cnt_max);
    assign w_stop_end = w_bit_end & (r_stop_idx == lp_two_stop);
    // A held byte starts from IDLE, or straight out of the last stop bit with no idle cycle.
    assign w_load     = r_hold_valid &
                        ((r_state == S_IDLE) | ((r_state == S_STOP) & w_stop_end));

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= 8'd0;
        end else if (w_load) begin
            r_hold_valid <= 1'b0;
        end else if (w_accept) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            r_shift    <= 8'd0;
            r_parity   <= 1'b0;
            r_stop_idx <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_cnt  <= ((r_state == S_IDLE) || w_bit_end) ? '0 : r_cnt + lp_cnt_one;
            r_done <= (r_state == S_STOP) & w_stop_end;
            if (w_load) begin
                r_state    <= S_START;
                r_shift    <= r_hold_data;
                r_parity   <= ^r_hold_data;
                r_idx      <= 3'd0;
                r_stop_idx <= 1'b0;
                r_tx       <= 1'b0;
            end else begin
                case (r_state)
                    S_START: begin
                        if (w_bit_end) begin
                            r_state <= S_DATA;
                            r_idx   <= 3'd0;
                            r_tx    <= r_shift[0];
                        end
                    end
                    S_DATA: begin
                        if (w_bit_end) begin
                            if (r_idx == 3'd7) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_idx <= r_idx + 3'd1;
                                r_tx  <= r_shift[r_idx + 3'd1];
                            end
                        end
                    end
                    S_PARITY: begin
                        if (w_bit_end) begin
                            r_state    <= S_STOP;
                            r_stop_idx <= 1'b0;
                            r_tx       <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (w_bit_end) begin
                            if (w_stop_end) begin
                                r_state <= S_IDLE;
                                r_tx    <= 1'b1;
                            end else begin
                                r_stop_idx <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_ready = ~r_hold_valid;
    assign o_tx    = r_tx;
    assign o_busy  = (r_state != S_IDLE);
    assign o_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: two transmitters (1 and 2 stop bits, DIV = 10) checked every cycle against a frame-timeline model.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int DIV  = 10;
    localparam int MAXF = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n;
    logic [1:0] val;
    logic [7:0] dat [2];
    logic [1:0] rdy_w, tx_w, busy_w, done_w;

    uart_tx #(.p_clk_freq(50000000), .p_baud_freq(5000000), .p_stop_bits(1)) u_dut_s1 (
        .i_clk(clk), .i_rst(rst_n[0]), .i_data(dat[0]), .i_valid(val[0]),
        .o_ready(rdy_w[0]), .o_tx(tx_w[0]), .o_busy(busy_w[0]), .o_done(done_w[0]));

    uart_tx #(.p_clk_freq(50000000), .p_baud_freq(5000000), .p_stop_bits(2)) u_dut_s2 (
        .i_clk(clk), .i_rst(rst_n[1]), .i_data(dat[1]), .i_valid(val[1]),
        .o_ready(rdy_w[1]), .o_tx(tx_w[1]), .o_busy(busy_w[1]), .o_done(done_w[1]));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    string nm [2] = '{"s1", "s2"};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: a list of frames (accept edge, start edge, byte) per transmitter.
    int         f_acc   [2][MAXF];
    int         f_start [2][MAXF];
    logic [7:0] f_data  [2][MAXF];
    int         n_fr     [2] = '{0, 0};
    int         last_end [2] = '{0, 0};
    bit         chk_en   [2] = '{1'b0, 1'b0};

    function automatic int frame_len(input int d);
        return (10 + ((d == 0) ? 1 : 2)) * DIV;
    endfunction

    task automatic model_at(input int d, input int e,
                            output logic tx, output logic busy, output logic done, output logic rdy);
        tx = 1'b1; busy = 1'b0; done = 1'b0; rdy = 1'b1;
        for (int i = 0; i < n_fr[d]; i++) begin
            int s, len, k;
            logic [7:0] b;
            s   = f_start[d][i];
            len = frame_len(d);
            b   = f_data[d][i];
            if (e >= f_acc[d][i] && e < s) rdy = 1'b0;
            if (e >= s && e < s + len) begin
                busy = 1'b1;
                k = (e - s) / DIV;
                if (k == 0)      tx = 1'b0;
                else if (k <= 8) tx = b[k-1];
                else if (k == 9) tx = ^b;
                else             tx = 1'b1;
            end
            if (e == s + len) done = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic etx, ebusy, edone, erdy;
            int a, s;
            model_at(d, cyc, etx, ebusy, edone, erdy);
            if (chk_en[d]) begin
                check_eq({"tx_",    nm[d]}, 32'(tx_w[d]),   32'(etx));
                check_eq({"busy_",  nm[d]}, 32'(busy_w[d]), 32'(ebusy));
                check_eq({"done_",  nm[d]}, 32'(done_w[d]), 32'(edone));
                check_eq({"ready_", nm[d]}, 32'(rdy_w[d]),  32'(erdy));
            end
            // Events landing on the next rising edge.
            if (!rst_n[d]) begin
                n_fr[d]     = 0;
                last_end[d] = 0;
                chk_en[d]   = 1'b1;
            end else if (chk_en[d] && val[d] && erdy) begin
                a = cyc + 1;
                s = (a + 1 > last_end[d]) ? a + 1 : last_end[d];
                if (n_fr[d] < MAXF) begin
                    f_acc[d][n_fr[d]]   = a;
                    f_start[d][n_fr[d]] = s;
                    f_data[d][n_fr[d]]  = dat[d];
                    n_fr[d]++;
                end
                last_end[d] = s + frame_len(d);
            end
        end
    end

    task automatic send(input int d, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        val[d] = 1'b1;
        dat[d] = b;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            if (rdy_w[d]) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        val[d] = 1'b0;
        check_eq("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 1000 && !ok; k++) begin
            @(negedge clk);
            if (!busy_w[d] && rdy_w[d]) ok = 1'b1;
        end
        check_eq("idle_reached", 32'(ok), 32'd1);
        repeat (5) @(posedge clk);
        #1;
    endtask

    int t0, tf, td, t1;
    bit seen;

    initial begin
        rst_n = 2'b00; val = 2'b00; dat[0] = 8'd0; dat[1] = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 2'b11;
        repeat (3) @(posedge clk);
        #1;

        // Single byte 0x55: latency and frame length.
        send(0, 8'h55);
        t0 = cyc; tf = -1; td = -1; seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (tf < 0 && tx_w[0] == 1'b0) tf = cyc;
            if (done_w[0]) begin
                seen = 1'b1;
                td = cyc;
                check_eq("busy_after_done", 32'(busy_w[0]), 32'd0);
            end
        end
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("fall_latency", 32'(tf - t0), 32'd1);
        check_eq("done_latency", 32'(td - tf), 32'd110);
        wait_idle(0);

        // 0xA7: parity bit is 1 (mid-bit sample of the parity slot).
        send(0, 8'hA7);
        repeat (96) @(negedge clk);
        check_eq("parity_a7", 32'(tx_w[0]), 32'd1);
        wait_idle(0);

        // Back-to-back 0x00 then 0xFF: done pulses one frame apart.
        send(0, 8'h00);
        send(0, 8'hFF);
        t1 = -1; td = -1; seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (done_w[0]) begin
                if (t1 < 0) t1 = cyc;
                else begin td = cyc; seen = 1'b1; end
            end
        end
        check_eq("b2b_two_done", 32'(seen), 32'd1);
        check_eq("b2b_done_gap", 32'(td - t1), 32'd110);
        wait_idle(0);

        // Reset during data bit 3 of 0x3C with a second byte held.
        send(0, 8'h3C);
        send(0, 8'h5A);
        repeat (43) @(posedge clk);
        #1 rst_n[0] = 1'b0;
        @(posedge clk);
        #1 rst_n[0] = 1'b1;
        @(negedge clk);
        check_eq("rst_tx",    32'(tx_w[0]),   32'd1);
        check_eq("rst_ready", 32'(rdy_w[0]),  32'd1);
        check_eq("rst_busy",  32'(busy_w[0]), 32'd0);
        repeat (300) @(posedge clk);
        #1;

        // Two stop bits, 0x81 with a second byte held during the frame.
        send(1, 8'h81);
        t0 = cyc;
        send(1, 8'($urandom));
        td = -1; seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (done_w[1]) begin
                seen = 1'b1;
                td = cyc;
                check_eq("s2_next_start", 32'(tx_w[1]), 32'd0);
            end
        end
        check_eq("s2_done_seen", 32'(seen), 32'd1);
        check_eq("s2_done_latency", 32'(td - t0), 32'd121);
        wait_idle(1);

        // Randomised traffic with occasional resets on both transmitters.
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                val[d]   = ($urandom_range(0, 5) == 0);
                dat[d]   = 8'($urandom);
                rst_n[d] = ($urandom_range(0, 1499) != 0);
            end
        end
        @(posedge clk);
        #1 val = 2'b00; rst_n = 2'b11;
        repeat (300) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", n_errors);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8-bit UART transmitter. It serialises one byte per frame: start bit, 8 data bits LSB first, even parity bit, then 1 or 2 stop bits.
- It is the transmit-side counterpart of the UART receiver and uses the same frame format. Parity bit = XOR of the data bits, so the receiver flags an error when the data XOR parity is 1.
- Has a one-entry holding register so that back-to-back frames go out with no idle gap.
- Sits between the host-side byte producer (valid/ready) and the serial TX pin.

Parameters:
- p_clk_freq, 50000000, i_clk frequency in Hz.
- p_baud_freq, 115200, line bit rate in Hz. Bit period DIV = p_clk_freq / p_baud_freq (integer division, truncated). DIV must be at least 2.
- p_stop_bits, 1, number of stop bits. Legal values are 1 or 2; any other value is treated as 1.

Ports:
- i_clk  input  1  system clock; all logic is on the rising edge.
- i_rst  input  1  reset, synchronous, active-low.
- i_data  input  8  byte to transmit; sampled when i_valid & o_ready.
- i_valid  input  1  producer has a byte on i_data.
- o_ready  output  1  holding register empty; o_ready = ~hold_valid (combinational from a register).
- o_tx  output  1  serial line, idle high, driven from a register.
- o_busy  output  1  high while a frame is on the line (state != IDLE).
- o_done  output  1  one-cycle pulse on the cycle after the final stop bit completes.

Behaviour:
- Reset: when i_rst is low at a rising edge, the block enters the reset state regardless of any frame in progress. Values after that edge:
  - o_tx = 1, state = IDLE.
  - hold_valid = 0, so o_ready = 1.
  - o_busy = 0, o_done = 0.
  - baud counter = 0, bit index = 0, shift register = 0.
  - A frame in progress is abandoned and its held byte is discarded.
- Accept: on an edge where i_valid & o_ready, the holding register captures i_data and hold_valid becomes 1. With o_ready low, i_valid is ignored and i_data is not sampled.
- Baud counter: counts 0..DIV-1 and wraps. Its terminal count (cnt == DIV-1) ends the current bit. Every bit lasts exactly DIV i_clk cycles. The counter is held at 0 in IDLE.
- States (3-bit encoding):
  - IDLE: o_tx = 1. If hold_valid, the next edge goes to START. On that same edge the block:
    - loads the shift register from the holding register;
    - computes parity = ^data;
    - clears hold_valid;
    - drives o_tx = 0.
  - START: o_tx = 0 for DIV cycles, then goes to DATA with bit index 0.
  - DATA: o_tx = shift[index] for DIV cycles per bit. The index increments at each terminal count. After index 7 completes, goes to PARITY.
  - PARITY: o_tx = parity bit for DIV cycles, then goes to STOP.
  - STOP: o_tx = 1 for DIV × p_stop_bits cycles. At completion the block pulses o_done. It then either:
    - goes straight to START, loading the next byte, if hold_valid (no idle cycle between frames); or
    - goes to IDLE otherwise.
- Latency: a byte accepted at edge k, with the engine in IDLE, drives o_tx low at edge k+1.
- Frame length: (10 + p_stop_bits) × DIV cycles. A frame in progress is never altered by new writes.
- Simultaneous accept and consume cannot occur, because o_ready is low whenever hold_valid is 1. A write accepted during a frame waits in the holding register.
- o_busy is 1 from the START entry edge up to and including the last stop-bit cycle.

Test Plan:
- Clock and divider settings used by every scenario: p_clk_freq = 50000000, p_baud_freq = 5000000 (DIV = 10), p_stop_bits = 1.
- Single byte 0x55: after reset, pulse i_valid with 0x55 →
  - o_tx falls 1 cycle later;
  - line sequence, each bit 10 cycles: 0,1,0,1,0,1,0,1,0, parity 0, stop 1;
  - o_done pulses 110 cycles after o_tx falls;
  - o_busy then drops.
- Odd-parity byte 0xA7 →
  - data bits LSB first: 1,1,1,0,0,1,0,1;
  - parity bit = 1;
  - a loopback into the UART receiver gives o_new with o_err = 0 and o_data = 0xA7.
- Back-to-back 0x00 then 0xFF, the second written during the first frame →
  - o_ready is low from the second accept until frame 2 starts;
  - the stop bit of frame 1 is followed directly by the start bit of frame 2, with no idle cycle;
  - frame 2 parity bit = 0;
  - two o_done pulses, 110 cycles apart.
- Reset mid-frame: assert i_rst low during DATA bit 3 of 0x3C, with a byte also held →
  - o_tx = 1, o_ready = 1, o_busy = 0 at the next edge;
  - after release, the line stays idle high and no further frame is sent.
- p_stop_bits = 2 with byte 0x81 →
  - stop high for 20 cycles;
  - o_done arrives 120 cycles after the start edge;
  - a write held during the frame starts exactly after both stop bits.
